// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// Per-channel sample packer: gathers PACK_RATIO formatted beats into one wide word on a valid/ready output.
// Optional drop counter is enabled by defining AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN.
module ad_ip_jesd204_tpl_adc_pack #(
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DATA_PATH_WIDTH = 2,
    parameter int PACK_RATIO      = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               enable,
    input  logic                                               in_valid,
    input  logic [BITS_PER_SAMPLE*DATA_PATH_WIDTH-1:0]            in_data,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [BITS_PER_SAMPLE*DATA_PATH_WIDTH*PACK_RATIO-1:0] out_data,
    output logic                                               ovf,
    input  logic                                               ovf_clr
`ifdef AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN
    ,
    output logic [31:0]                                        drop_count
`endif
);

    localparam int IN_W  = BITS_PER_SAMPLE * DATA_PATH_WIDTH;
    localparam int OUT_W = IN_W * PACK_RATIO;
    localparam int CNT_W = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_acc;
    logic [OUT_W-1:0] w_acc_next;
    logic [OUT_W-1:0] w_word;
    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic             w_drop;

    assign w_accept = enable & in_valid;
    assign w_last   = w_accept & (r_cnt == CNT_W'(PACK_RATIO - 1));
    // A completed word may only replace the output register if it is empty or being consumed now.
    assign w_load   = w_last & (~out_valid | out_ready);
    assign w_drop   = w_last & out_valid & ~out_ready;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_acc_next[k*IN_W +: IN_W] = in_data;
            end
        end
    end

    // The final beat goes straight into the output word, bypassing the accumulator.
    always_comb begin
        w_word = r_acc;
        w_word[(PACK_RATIO-1)*IN_W +: IN_W] = in_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (!enable) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (in_valid) begin
                if (w_last) begin
                    r_cnt <= '0;
                    r_acc <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= w_acc_next;
                end
            end

            if (w_load) begin
                out_data  <= w_word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (w_drop) begin
            if (ovf_clr) begin
                drop_count <= 32'd1;
            end else if (drop_count != 32'hFFFF_FFFF) begin
                drop_count <= drop_count + 32'd1;
            end
        end else if (ovf_clr) begin
            drop_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pack.sv
// Self-checking bench for ad_ip_jesd204_tpl_adc_pack: directed scenarios plus random traffic against a queue-based model.
// Define AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN to also check drop_count.
module tb_ad_ip_jesd204_tpl_adc_pack;

    localparam int BPS   = 16;
    localparam int DPW   = 2;
    localparam int PR    = 4;
    localparam int IN_W  = BPS * DPW;
    localparam int OUT_W = IN_W * PR;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             ovf;
    logic             ovf_clr;
`ifdef AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN
    logic [31:0]      drop_count;
`endif

    ad_ip_jesd204_tpl_adc_pack #(
        .BITS_PER_SAMPLE (BPS),
        .DATA_PATH_WIDTH (DPW),
        .PACK_RATIO      (PR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`ifdef AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats of the word in progress, plus the visible output state.
    logic [IN_W-1:0]  m_q[$];
    logic             m_valid;
    logic [OUT_W-1:0] m_data;
    logic             m_ovf;
    logic [31:0]      m_drop;

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] word4(input int b3, input int b2, input int b1, input int b0);
        logic [OUT_W-1:0] w;
        w = {IN_W'(b3), IN_W'(b2), IN_W'(b1), IN_W'(b0)};
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_drop  = '0;
    endtask

    task automatic model_step(input logic en, input logic iv, input logic [IN_W-1:0] d,
                              input logic rdy, input logic clr);
        logic             loaded;
        logic             dropped;
        logic [OUT_W-1:0] w;
        loaded  = 1'b0;
        dropped = 1'b0;
        if (!en) begin
            m_q.delete();
        end else if (iv) begin
            m_q.push_back(d);
            if (m_q.size() == PR) begin
                w = '0;
                for (int i = 0; i < PR; i++) w[i*IN_W +: IN_W] = m_q[i];
                m_q.delete();
                if (!m_valid || rdy) begin
                    m_data = w;
                    loaded = 1'b1;
                end else begin
                    dropped = 1'b1;
                end
            end
        end
        if (loaded) m_valid = 1'b1;
        else if (rdy) m_valid = 1'b0;
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (dropped) m_drop = clr ? 32'd1 : ((m_drop == 32'hFFFF_FFFF) ? m_drop : m_drop + 32'd1);
        else if (clr) m_drop = '0;
    endtask

    task automatic compare_outputs();
        check("out_valid", OUT_W'(out_valid), OUT_W'(m_valid));
        check("out_data", out_data, m_data);
        check("ovf", OUT_W'(ovf), OUT_W'(m_ovf));
`ifdef AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN
        check("drop_count", OUT_W'(drop_count), OUT_W'(m_drop));
`endif
    endtask

    // One clock: check what the previous edge produced, then drive the next inputs.
    task automatic cycle(input logic en, input logic iv, input logic [IN_W-1:0] d,
                         input logic rdy, input logic clr);
        @(negedge clk);
        compare_outputs();
        enable    = en;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        ovf_clr   = clr;
        model_step(en, iv, d, rdy, clr);
    endtask

    task automatic idle_inputs();
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_valid", OUT_W'(out_valid), '0);
        check("reset_data", out_data, '0);
        check("reset_ovf", OUT_W'(ovf), '0);
        reset = 1'b0;

        // Back-to-back beats 0..7 with a ready consumer.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, IN_W'(i), 1'b1, 1'b0);
            if (i == 3 || i == 7) begin
                @(posedge clk); #1;
                check("t1_valid", OUT_W'(out_valid), OUT_W'(1));
                check("t1_word", out_data, (i == 3) ? word4(3, 2, 1, 0) : word4(7, 6, 5, 4));
                check("t1_ovf", OUT_W'(ovf), '0);
            end
        end

        // Stalled consumer: first word held, following words dropped.
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, IN_W'(32'h100 + i), 1'b0, 1'b0);
            if (i == 3 || i == 7 || i == 15) begin
                @(posedge clk); #1;
                check("t2_held", out_data, word4('h103, 'h102, 'h101, 'h100));
                check("t2_ovf", OUT_W'(ovf), OUT_W'(i != 3));
`ifdef AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN
                check("t2_drops", OUT_W'(drop_count), OUT_W'((i == 3) ? 0 : (i == 7) ? 1 : 3));
`endif
            end
        end

        // Enable drop discards the partial word.
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, IN_W'(1), 1'b1, 1'b0);
        cycle(1'b1, 1'b1, IN_W'(2), 1'b1, 1'b0);
        cycle(1'b0, 1'b1, IN_W'(9), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, IN_W'(32'hA + i), 1'b1, 1'b0);
        @(posedge clk); #1;
        check("t3_word", out_data, word4('hD, 'hC, 'hB, 'hA));
        check("t3_ovf", OUT_W'(ovf), '0);

        // Gapped input: beats on alternate cycles.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i % 2) == 0, IN_W'(32'h10 + i), 1'b1, 1'b0);
            if (i == 6) begin
                @(posedge clk); #1;
                check("t4_valid", OUT_W'(out_valid), OUT_W'(1));
                check("t4_word", out_data, word4('h16, 'h14, 'h12, 'h10));
            end
        end

        // New word completes in the same cycle the pending one is taken.
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, IN_W'(32'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, IN_W'(32'h30 + i), i == 3, 1'b0);
        @(posedge clk); #1;
        check("t5_valid", OUT_W'(out_valid), OUT_W'(1));
        check("t5_word", out_data, word4('h33, 'h32, 'h31, 'h30));
        check("t5_ovf", OUT_W'(ovf), '0);

        // Asynchronous reset mid-word with a word pending.
        cycle(1'b1, 1'b1, IN_W'(32'h40), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, IN_W'(32'h41), 1'b0, 1'b0);
        @(posedge clk); #2;
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check("t6_rst_valid", OUT_W'(out_valid), '0);
        check("t6_rst_data", out_data, '0);
        check("t6_rst_ovf", OUT_W'(ovf), '0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, IN_W'(32'h50 + i), 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t6_word", out_data, word4('h53, 'h52, 'h51, 'h50));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, IN_W'(32'h60 + i), 1'b0, i == 3);
        @(posedge clk); #1;
        check("t6_set_wins", OUT_W'(ovf), OUT_W'(1));
        check("t6_kept", out_data, word4('h53, 'h52, 'h51, 'h50));
`ifdef AD_IP_JESD204_TPL_ADC_PACK_DROP_CNT_EN
        check("t6_drop_one", OUT_W'(drop_count), OUT_W'(1));
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, IN_W'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        compare_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
